poly_tone_gen: RTL and testbench

Multi-channel square-wave tone generator, the parametrised successor to the single-channel frequency generator. Each channel is programmed with a frequency in Hz over a valid/ready config port. A shared sequential divider converts that frequency to a half-period count, so the block needs no combinational divider. Per-channel tone outputs and a registered voice-count mix feed the audio output stage.

---
 rtl/poly_tone_gen.sv | 153 +++++++++++++++
 tb/tb_poly_tone_gen.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_tone_gen.sv
// Multi-channel square-wave tone generator with frequencies in Hz.
// A shared sequential restoring divider turns each request into a half-period count.
module poly_tone_gen #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned FREQ_W = 16,
  parameter int unsigned CNT_W  = 32,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned MIX_W = $clog2(NUM_CH + 1)
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_chan,
  input  logic [FREQ_W-1:0] cfg_freq,
  output logic              busy,
  output logic [NUM_CH-1:0] tone_out,
  output logic [NUM_CH-1:0] tone_active,
  output logic [MIX_W-1:0]  mix_out
);

  localparam int unsigned DIV_W  = FREQ_W + 1;
  localparam int unsigned REM_W  = FREQ_W + 2;
  localparam int unsigned CHX_W  = CH_W + 1;
  localparam int unsigned STEP_W = $clog2(CNT_W + 1);
  localparam logic [CHX_W-1:0]  NUM_CH_L  = CHX_W'(NUM_CH);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(CNT_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_COMMIT} state_t;

  state_t             state;
  logic [CH_W-1:0]    chan_q;
  logic               freq_nz;
  logic [DIV_W-1:0]   divisor;
  logic [CNT_W-1:0]   dvd;
  logic [DIV_W-1:0]   rem;
  logic [CNT_W-1:0]   quo;
  logic [STEP_W-1:0]  step;

  logic               chan_ok;
  logic [REM_W-1:0]   rem_sh;
  logic               q_bit;
  logic [DIV_W-1:0]   rem_nxt;
  logic [CNT_W-1:0]   half_nxt;
  logic               commit;

  logic [CNT_W-1:0]   half_period [NUM_CH];
  logic [CNT_W-1:0]   counter     [NUM_CH];

  // One restoring-divide step; the remainder stays below the divisor so DIV_W bits suffice.
  always_comb begin
    chan_ok  = {1'b0, cfg_chan} < NUM_CH_L;
    rem_sh   = {rem, dvd[CNT_W-1]};
    q_bit    = rem_sh >= {1'b0, divisor};
    rem_nxt  = q_bit ? DIV_W'(rem_sh - {1'b0, divisor}) : DIV_W'(rem_sh);
    half_nxt = (quo == '0) ? CNT_W'(1) : quo;
    commit   = (state == S_COMMIT);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      chan_q    <= '0;
      freq_nz   <= 1'b0;
      divisor   <= '0;
      dvd       <= '0;
      rem       <= '0;
      quo       <= '0;
      step      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Out-of-range channels are accepted and silently dropped.
          if (cfg_valid && chan_ok) begin
            chan_q    <= cfg_chan;
            freq_nz   <= (cfg_freq != '0);
            divisor   <= {cfg_freq, 1'b0};
            dvd       <= CNT_W'(CLK_HZ);
            rem       <= '0;
            quo       <= '0;
            step      <= '0;
            cfg_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= (cfg_freq != '0) ? S_DIV : S_COMMIT;
          end
        end
        S_DIV: begin
          dvd  <= dvd << 1;
          rem  <= rem_nxt;
          quo  <= {quo[CNT_W-2:0], q_bit};
          step <= step + STEP_W'(1);
          if (step == LAST_STEP) state <= S_COMMIT;
        end
        S_COMMIT: begin
          state     <= S_IDLE;
          cfg_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          cfg_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel half-period counters; a commit restarts that channel's phase.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      tone_out    <= '0;
      tone_active <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        half_period[i] <= '0;
        counter[i]     <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (commit && chan_q == CH_W'(i)) begin
          half_period[i] <= half_nxt;
          tone_active[i] <= freq_nz;
          counter[i]     <= '0;
          tone_out[i]    <= 1'b0;
        end else if (!enable || !tone_active[i]) begin
          counter[i]  <= '0;
          tone_out[i] <= 1'b0;
        end else if (counter[i] == half_period[i] - CNT_W'(1)) begin
          counter[i]  <= '0;
          tone_out[i] <= ~tone_out[i];
        end else begin
          counter[i] <= counter[i] + CNT_W'(1);
        end
      end
    end
  end

  function automatic logic [MIX_W-1:0] popcount(input logic [NUM_CH-1:0] v);
    logic [MIX_W-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) s = s + MIX_W'(v[i]);
    return s;
  endfunction

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) mix_out <= '0;
    else          mix_out <= popcount(tone_out);
  end

endmodule

// File: tb/tb_poly_tone_gen.sv
// Scoreboard bench for poly_tone_gen: a timeline model predicts every cycle's outputs,
// plus a directed check of the 440 Hz case on a default-parameter instance.
module tb_poly_tone_gen;

  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned NUM_CH = 5;
  localparam int unsigned FREQ_W = 16;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned MIX_W  = 3;

  logic CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic              reset_n;
  logic              enable;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_chan;
  logic [FREQ_W-1:0] cfg_freq;
  logic              busy;
  logic [NUM_CH-1:0] tone_out;
  logic [NUM_CH-1:0] tone_active;
  logic [MIX_W-1:0]  mix_out;

  poly_tone_gen #(.CLK_HZ(CLK_HZ), .NUM_CH(NUM_CH), .FREQ_W(FREQ_W), .CNT_W(CNT_W)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan), .cfg_freq(cfg_freq),
    .busy(busy), .tone_out(tone_out), .tone_active(tone_active), .mix_out(mix_out)
  );

  // Default-parameter instance for the 440 Hz check.
  logic        d_enable, d_cfg_valid, d_cfg_ready, d_busy;
  logic [1:0]  d_cfg_chan;
  logic [15:0] d_cfg_freq;
  logic [3:0]  d_tone_out, d_tone_active;
  logic [2:0]  d_mix_out;

  poly_tone_gen d2 (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .enable(d_enable),
    .cfg_valid(d_cfg_valid), .cfg_ready(d_cfg_ready), .cfg_chan(d_cfg_chan), .cfg_freq(d_cfg_freq),
    .busy(d_busy), .tone_out(d_tone_out), .tone_active(d_tone_active), .mix_out(d_mix_out)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [NUM_CH-1:0] tone;
    logic [NUM_CH-1:0] act;
    logic [MIX_W-1:0]  mix;
    logic              ready;
    logic              busy;
  } exp_t;

  exp_t exp_q[$];

  // Model: each channel is a square wave of period 2*half, phase anchored at m_start.
  longint            n;
  bit                pend;
  int                p_ch;
  longint            p_freq;
  longint            commit_at;
  bit                m_act   [NUM_CH];
  longint            m_half  [NUM_CH];
  longint            m_start [NUM_CH];
  logic [NUM_CH-1:0] prev_tone;
  bit                started = 1'b0;

  function automatic exp_t reset_exp();
    exp_t e;
    e.tone = '0; e.act = '0; e.mix = '0; e.ready = 1'b1; e.busy = 1'b0;
    return e;
  endfunction

  function automatic int ones(input logic [NUM_CH-1:0] v);
    int s = 0;
    for (int i = 0; i < int'(NUM_CH); i++) s += int'(v[i]);
    return s;
  endfunction

  always @(posedge CLOCK_50 or negedge reset_n) begin
    exp_t e;
    started = 1'b1;
    if (!reset_n) begin
      n = 0; pend = 1'b0; prev_tone = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        m_act[i] = 1'b0; m_half[i] = 0; m_start[i] = 0;
      end
      exp_q.delete();
      exp_q.push_back(reset_exp());
    end else begin
      n++;
      if (pend) begin
        if (n == commit_at) begin
          m_act[p_ch]   = (p_freq != 0);
          m_half[p_ch]  = (p_freq != 0) ? longint'(CLK_HZ) / (2 * p_freq) : 0;
          if (m_half[p_ch] < 1) m_half[p_ch] = 1;
          m_start[p_ch] = n;
          pend = 1'b0;
        end
      end else if (cfg_valid && int'(cfg_chan) < int'(NUM_CH)) begin
        pend      = 1'b1;
        p_ch      = int'(cfg_chan);
        p_freq    = longint'(cfg_freq);
        commit_at = n + ((cfg_freq != 0) ? longint'(CNT_W) + 1 : 1);
      end
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (!enable) m_start[i] = n;
        e.tone[i] = 1'b0;
        if (m_act[i] && enable) e.tone[i] = (((n - m_start[i]) / m_half[i]) % 2) == 1;
        e.act[i] = m_act[i];
      end
      e.mix     = MIX_W'(ones(prev_tone));
      prev_tone = e.tone;
      e.ready   = !pend;
      e.busy    = pend;
      exp_q.push_back(e);
    end
  end

  // Monitor: one expected entry per cycle, compared away from the active edge.
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (tone_out !== e.tone || tone_active !== e.act || mix_out !== e.mix ||
          cfg_ready !== e.ready || busy !== e.busy) begin
        bad++;
        $display("FAIL cycle n=%0d tone=%b/%b active=%b/%b mix=%0d/%0d ready=%b/%b busy=%b/%b (actual/expected)",
                 n, tone_out, e.tone, tone_active, e.act, mix_out, e.mix, cfg_ready, e.ready, busy, e.busy);
      end
    end else if (started) begin
      total++; bad++;
      $display("FAIL scoreboard_empty at n=%0d", n);
    end
  end

  task automatic idle(input int cyc);
    repeat (cyc) @(posedge CLOCK_50);
    #1;
  endtask

  // Present a request and hold it until the handshake edge; optionally keep valid high afterwards.
  task automatic send(input int ch, input int f, input bit hold);
    bit acc = 1'b0;
    cfg_chan  = CH_W'(ch);
    cfg_freq  = FREQ_W'(f);
    cfg_valid = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge CLOCK_50);
      acc = cfg_ready;
      @(posedge CLOCK_50);
      #1;
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL accept_timeout ch=%0d freq=%0d", ch, f);
    end
    if (!hold) cfg_valid = 1'b0;
  endtask

  task automatic d_send(input int ch, input int f);
    bit acc = 1'b0;
    d_cfg_chan  = 2'(ch);
    d_cfg_freq  = 16'(f);
    d_cfg_valid = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge CLOCK_50);
      acc = d_cfg_ready;
      @(posedge CLOCK_50);
      #1;
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL d2_accept_timeout ch=%0d freq=%0d", ch, f);
    end
    d_cfg_valid = 1'b0;
  endtask

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int r, ch, f;
    bit hold;
    reset_n = 1'b0; enable = 1'b1; cfg_valid = 1'b0; cfg_chan = '0; cfg_freq = '0;
    d_enable = 1'b1; d_cfg_valid = 1'b0; d_cfg_chan = '0; d_cfg_freq = '0;
    idle(3);
    reset_n = 1'b1;
    idle(2);

    // Two tones for the mix sequence: half periods 5 and 10.
    send(0, 100, 1'b0);
    send(1, 50, 1'b0);
    idle(80);

    // Reset in the middle of a divide aborts it and clears all channels.
    send(2, 200, 1'b0);
    idle(10);
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(40);

    // Back-to-back requests including the clamped high-frequency case.
    send(0, 100, 1'b1);
    send(1, 50, 1'b1);
    send(2, 600, 1'b1);
    send(3, 250, 1'b0);
    idle(80);

    // Out-of-range channels are dropped without a busy cycle.
    send(5, 123, 1'b0);
    send(7, 0, 1'b0);
    idle(5);

    enable = 1'b0;
    idle(4);
    send(4, 125, 1'b0);
    idle(40);
    enable = 1'b1;
    idle(30);

    for (int it = 0; it < 40; it++) begin
      r  = int'($urandom_range(0, 9));
      ch = int'($urandom_range(0, 7));
      if (r < 2)      f = 0;
      else if (r < 8) f = int'($urandom_range(1, 600));
      else            f = int'($urandom_range(0, 65535));
      hold = 1'($urandom_range(0, 1));
      send(ch, f, hold);
      if (!hold) idle(int'($urandom_range(0, 30)));
      if ($urandom_range(0, 5) == 0) enable = ~enable;
    end
    cfg_valid = 1'b0;
    enable = 1'b1;
    idle(40);
    send(1, 0, 1'b0);
    idle(50);

    // 440 Hz on default parameters: busy for CNT_W+1 cycles, first rise after 56818 cycles.
    d_send(1, 440);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLOCK_50);
      if (!d_busy) break;
      cnt++;
    end
    check("d2_busy_cycles", cnt, 33);
    cnt = 0;
    for (int k = 0; k < 60000; k++) begin
      @(posedge CLOCK_50);
      #1;
      cnt++;
      if (d_tone_out[1]) break;
    end
    check("d2_first_rise", cnt, 50_000_000 / (2 * 440));
    check("d2_active_440", longint'(d_tone_active[1]), 1);
    d_send(1, 0);
    @(negedge CLOCK_50);
    check("d2_active_before_commit", longint'(d_tone_active[1]), 1);
    @(negedge CLOCK_50);
    check("d2_active_after_zero", longint'(d_tone_active[1]), 0);
    check("d2_tone_after_zero", longint'(d_tone_out[1]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
